// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter: shares one CORDIC core between two requesters.
// Round-robin issue, a tag FIFO that remembers who owns each in-flight operation,
// and per-requester result FIFOs guarded by credits so the core output never stalls.
`timescale 1ns/1ps
module cordic_share_arbiter #(
  parameter int unsigned DIN_W        = 32,
  parameter int unsigned DOUT_W       = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned MAX_INFLIGHT = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  // requester 0 operand
  input  logic [DIN_W-1:0]              s0_tdata,
  input  logic                          s0_tvalid,
  output logic                          s0_tready,
  // requester 1 operand
  input  logic [DIN_W-1:0]              s1_tdata,
  input  logic                          s1_tvalid,
  output logic                          s1_tready,
  // result to requester 0
  output logic [DOUT_W-1:0]             m0_tdata,
  output logic                          m0_tvalid,
  input  logic                          m0_tready,
  // result to requester 1
  output logic [DOUT_W-1:0]             m1_tdata,
  output logic                          m1_tvalid,
  input  logic                          m1_tready,
  // shared core
  output logic [DIN_W-1:0]              core_s_tdata,
  output logic                          core_s_tvalid,
  input  logic                          core_s_tready,
  input  logic [DOUT_W-1:0]             core_m_tdata,
  input  logic                          core_m_tvalid,
  // status
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err
);

  localparam int unsigned TagAw = $clog2(MAX_INFLIGHT);
  localparam int unsigned ResAw = $clog2(DEPTH);

  localparam logic [TagAw:0] TagFull = (TagAw+1)'(MAX_INFLIGHT);
  localparam logic [TagAw:0] TagOne  = (TagAw+1)'(1);
  localparam logic [ResAw:0] ResFull = (ResAw+1)'(DEPTH);
  localparam logic [ResAw:0] ResOne  = (ResAw+1)'(1);

  // Tag FIFO: one bit per in-flight operation, 1 = requester 1.
  logic [MAX_INFLIGHT-1:0] r_tag_mem;
  logic [TagAw:0]          r_tag_wptr;
  logic [TagAw:0]          r_tag_rptr;

  // Result FIFOs and credit counters, indexed by requester.
  logic [DOUT_W-1:0]       r_res_mem  [2][DEPTH];
  logic [ResAw:0]          r_res_wptr [2];
  logic [ResAw:0]          r_res_rptr [2];
  logic [ResAw:0]          r_credit   [2];

  logic                    r_rr;
  logic                    r_err;

  logic [TagAw:0]          w_tag_cnt;
  logic                    w_tag_full;
  logic                    w_tag_empty;
  logic                    w_tag_push;
  logic                    w_tag_pop;
  logic                    w_tag_head;
  logic [1:0]              w_svalid;
  logic [1:0]              w_elig;
  logic [1:0]              w_grant;
  logic [1:0]              w_mready;
  logic [1:0]              w_res_valid;
  logic [1:0]              w_res_full;
  logic [1:0]              w_res_wr;
  logic [1:0]              w_res_pop;
  logic [ResAw:0]          w_res_cnt [2];
  logic                    w_err_set;

  // Eligibility and round-robin grant; nothing is granted while the core is busy.
  always_comb begin
    w_svalid    = {s1_tvalid, s0_tvalid};
    w_tag_cnt   = r_tag_wptr - r_tag_rptr;
    w_tag_full  = (w_tag_cnt == TagFull);
    w_tag_empty = (w_tag_cnt == '0);
    for (int k = 0; k < 2; k++) begin
      w_elig[k] = w_svalid[k] & (r_credit[k] != '0) & ~w_tag_full;
    end
    // r_rr = 0 favours requester 0 when both are eligible.
    w_grant[0] = core_s_tready & w_elig[0] & (~w_elig[1] | ~r_rr);
    w_grant[1] = core_s_tready & w_elig[1] & (~w_elig[0] |  r_rr);
  end

  // Issue side outputs: at most one grant bit is ever set.
  always_comb begin
    s0_tready     = w_grant[0];
    s1_tready     = w_grant[1];
    core_s_tvalid = |w_grant;
    if (w_grant[1]) begin
      core_s_tdata = s1_tdata;
    end else if (w_grant[0]) begin
      core_s_tdata = s0_tdata;
    end else begin
      core_s_tdata = '0;
    end
  end

  // Route core results by head tag and decide FIFO writes, pops and errors.
  always_comb begin
    w_tag_push = |w_grant;
    w_tag_pop  = core_m_tvalid & ~w_tag_empty;
    w_tag_head = r_tag_mem[r_tag_rptr[TagAw-1:0]];
    w_mready   = {m1_tready, m0_tready};
    // A result with no owner is dropped and flagged.
    w_err_set  = core_m_tvalid & w_tag_empty;
    for (int k = 0; k < 2; k++) begin
      w_res_cnt[k]   = r_res_wptr[k] - r_res_rptr[k];
      w_res_full[k]  = (w_res_cnt[k] == ResFull);
      w_res_valid[k] = (w_res_cnt[k] != '0);
      w_res_pop[k]   = w_res_valid[k] & w_mready[k];
      w_res_wr[k]    = w_tag_pop & (w_tag_head == 1'(k)) & ~w_res_full[k];
      // Credits make this unreachable; kept as a safety net that never overwrites.
      w_err_set      = w_err_set | (w_tag_pop & (w_tag_head == 1'(k)) & w_res_full[k]);
    end
  end

  // Result-side outputs: first-word fall-through, zero when empty.
  always_comb begin
    m0_tvalid = w_res_valid[0];
    m1_tvalid = w_res_valid[1];
    m0_tdata  = w_res_valid[0] ? r_res_mem[0][r_res_rptr[0][ResAw-1:0]] : '0;
    m1_tdata  = w_res_valid[1] ? r_res_mem[1][r_res_rptr[1][ResAw-1:0]] : '0;
    inflight  = w_tag_cnt;
    err       = r_err;
  end

  // Tag FIFO, round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_mem  <= '0;
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      r_rr       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_tag_push) begin
        r_tag_mem[r_tag_wptr[TagAw-1:0]] <= w_grant[1];
        r_tag_wptr                       <= r_tag_wptr + TagOne;
        // Favour the other requester next time; pointer only moves on issue.
        r_rr                             <= ~w_grant[1];
      end
      if (w_tag_pop) begin
        r_tag_rptr <= r_tag_rptr + TagOne;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Result FIFOs and per-requester credits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        r_res_wptr[k] <= '0;
        r_res_rptr[k] <= '0;
        r_credit[k]   <= ResFull;
        for (int d = 0; d < DEPTH; d++) begin
          r_res_mem[k][d] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_res_wr[k]) begin
          r_res_mem[k][r_res_wptr[k][ResAw-1:0]] <= core_m_tdata;
          r_res_wptr[k]                          <= r_res_wptr[k] + ResOne;
        end
        if (w_res_pop[k]) begin
          r_res_rptr[k] <= r_res_rptr[k] + ResOne;
        end
        // Issue consumes a credit, consumer pop returns one; both together cancel.
        r_credit[k] <= r_credit[k] - {{ResAw{1'b0}}, w_grant[k]}
                                   + {{ResAw{1'b0}}, w_res_pop[k]};
      end
    end
  end

endmodule

// File: doc/cordic_share_arbiter.md
Name: cordic_share_arbiter

Overview:
- Shares one fixed-function CORDIC core (translate or rotate) between two requesters in the barrel-distortion math path, e.g. the radius lookup and the phase/rotation stage.
- Round-robin issue, in-order tag tracking of in-flight operations, result routing back to the owning requester.
- Per-requester credit-protected result FIFOs, so the core output is never stalled.

Parameters:
DIN_W, 32, core input tdata width (packed Y[31:16], X[15:0] fixed point)
DOUT_W, 32, core output tdata width
DEPTH, 8, result FIFO depth per requester (power of 2, ≥2); also that requester's credit limit
MAX_INFLIGHT, 32, tag FIFO depth (power of 2); must be ≥ core latency + 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
s0_tdata  in  DIN_W  requester 0 operand
s0_tvalid  in  1  requester 0 valid
s0_tready  out  1  requester 0 accepted (combinational grant)
s1_tdata  in  DIN_W  requester 1 operand
s1_tvalid  in  1  requester 1 valid
s1_tready  out  1  requester 1 accepted
m0_tdata  out  DOUT_W  result to requester 0
m0_tvalid  out  1  result valid
m0_tready  in  1  requester 0 consumes
m1_tdata  out  DOUT_W  result to requester 1
m1_tvalid  out  1  result valid
m1_tready  in  1  requester 1 consumes
core_s_tdata  out  DIN_W  operand to core (muxed)
core_s_tvalid  out  1  issue to core
core_s_tready  in  1  core accepts
core_m_tdata  in  DOUT_W  core result
core_m_tvalid  in  1  core result valid (core output ready tied high; results cannot be refused)
inflight  out  6  tag FIFO occupancy, log2(MAX_INFLIGHT)+1 bits
err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, async): tag FIFO and both result FIFOs empty; credit0=credit1=DEPTH; rr pointer=0 (requester 0 favoured); m*_tvalid=0, m*_tdata=0, err=0, inflight=0. Reset mid-operation discards all in-flight tags and results. The core must share the same reset.
- Eligibility: elig_k = sk_tvalid & (credit_k>0) & (inflight<MAX_INFLIGHT).
- Grant:
  - Both eligible: grant rr.
  - One eligible: grant it.
  - Grant is valid only when core_s_tready=1.
- Issue outputs: core_s_tvalid = any grant. core_s_tdata = granted requester's tdata, else 0. sk_tready = grant_k. At most one sk_tready high per cycle.
- On issue (rising edge):
  - Push tag k into tag FIFO.
  - credit_k -= 1.
  - rr <= ~k. rr changes only on issue.
- On core_m_tvalid:
  - Pop head tag t.
  - Write core_m_tdata into result FIFO t.
  - If the tag FIFO is empty: discard the result and set err=1 (sticky until reset).
- Same-cycle issue and pop: tag FIFO push and pop both occur; inflight is unchanged.
- Result FIFO output: first-word fall-through, registered. A write at edge n makes mk_tvalid=1 after edge n if the FIFO was empty. mk_tdata holds stable while mk_tvalid & ~mk_tready.
- On mk_tvalid & mk_tready: pop, credit_k += 1. Same-cycle issue and pop for the same k leaves credit_k unchanged.
- Invariant: credit_k + (tags k in flight) + (FIFO k occupancy) = DEPTH, so result FIFO overflow is impossible. A FIFO-full write is still checked and sets err.
- Latency: issue at edge t, core latency L, result at edge t+L, mk_tvalid visible after edge t+L. Minimum request-to-response = L+1 cycles.
- Ordering: results per requester are returned in issue order. Requesters are independent; a stalled m0 never blocks requester 1 beyond the shared tag limit.
- No starvation: with both requesters continuously eligible, grants alternate 0,1,0,1.

Test Plan:
1. Reset, then s0 only (s0_tdata=32'h0010_0020, L=16, core returns input) -> s0_tready at cycle 0, m0_tvalid after 17 edges, m0_tdata=32'h0010_0020, inflight 1→0.
2. Both s0 and s1 valid continuously for 10 cycles, all readies high -> grants alternate 0,1,0,…; m0 gets 5 results and m1 gets 5, each in issue order; err=0.
3. m0_tready=0, s0 valid continuously -> exactly DEPTH=8 issues from s0 then s0_tready=0; s1 traffic continues at full rate. Raise m0_tready -> one s0 issue per credit returned.
4. core_s_tready=0 for 5 cycles with s0 and s1 valid -> no sk_tready, core_s_tvalid=0, rr unchanged; issue resumes on the release cycle with requester rr.
5. Inject core_m_tvalid with inflight=0 -> result dropped, err=1, stays 1 until reset.
6. Assert reset low with 6 ops in flight and 3 results buffered -> all m*_tvalid=0, inflight=0, credits=8 immediately (async); normal operation after reset returns high.
